// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one downstream cache/memory port among nport upstream ports and routes responses and miss callbacks back to the owning port.
// Build option MEM_ARB_FIXED_PRIO_EN selects fixed priority (lowest port wins); the default is round robin.
module mem_arbiter #(
  parameter int nport = 2,
  parameter int blk   = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [255:0]     flush,
  input  logic [7:0]       s_rqst [nport],
  input  logic [7:0]       s_trsc [nport],
  input  logic [blk-1:0]   s_strb [nport],
  input  logic [63:0]      s_addr [nport],
  input  logic [blk*8-1:0] s_wdat [nport],
  output logic [7:0]       s_resp [nport],
  output logic [7:0]       s_miss [nport],
  output logic [63:0]      s_ofst [nport],
  output logic [blk*8-1:0] s_rdat [nport],
  output logic [7:0]       m_rqst,
  output logic [7:0]       m_trsc,
  output logic [blk-1:0]   m_strb,
  output logic [63:0]      m_addr,
  output logic [blk*8-1:0] m_wdat,
  input  logic [7:0]       m_resp,
  input  logic [7:0]       m_miss,
  input  logic [63:0]      m_ofst,
  input  logic [blk*8-1:0] m_rdat
);

  localparam int pw = (nport > 1) ? $clog2(nport) : 1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]     state;
  logic [pw-1:0]  grant, rr_ptr, win, rr_nxt;
  logic [7:0]     gid;
  logic [255:0]   flush_m;
  logic [nport-1:0] cand;
  logic           keep, hit_grant, resp_ok, tgt_vld, cb_clr, own_ins;
  logic [pw-1:0]  tgt;
  logic [255:0]   own_vld;
  logic [pw-1:0]  own_port [256];

  // ID 0 means idle and can never be flushed.
  assign flush_m = flush & ~256'd1;

  always_comb begin
    for (int i = 0; i < nport; i++)
      cand[i] = (|s_rqst[i]) && !flush_m[s_rqst[i]];
  end

  // Circular search from rr_ptr; in fixed-priority builds rr_ptr stays 0,
  // so the same search picks the lowest candidate index.
  always_comb begin : arb
    logic [pw:0] j;
    logic        found;
    // NOTE: every combinational output gets a default first so no latch is inferred.
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < nport; k++) begin
      j = {1'b0, rr_ptr} + (pw+1)'(k);
      if (j >= (pw+1)'(nport)) j = j - (pw+1)'(nport);
      if (!found && cand[j[pw-1:0]]) begin
        found = 1'b1;
        win   = j[pw-1:0];
      end
    end
`ifdef MEM_ARB_FIXED_PRIO_EN
    rr_nxt = '0;
`else
    j = {1'b0, win} + (pw+1)'(1);
    if (j >= (pw+1)'(nport)) j = '0;
    rr_nxt = j[pw-1:0];
`endif
  end

  assign keep      = (s_rqst[grant] == gid) && !flush_m[gid];
  assign hit_grant = (state == BUSY) && (m_resp == gid);
  assign resp_ok   = (|m_resp) && !flush_m[m_resp];
  assign own_ins   = hit_grant && (|m_miss) && !flush_m[m_miss];

  always_comb begin
    m_rqst = '0;
    m_trsc = '0;
    m_strb = '0;
    m_addr = '0;
    m_wdat = '0;
    if (state == BUSY) begin
      m_rqst = keep ? gid : 8'd0;
      m_trsc = s_trsc[grant];
      m_strb = s_strb[grant];
      m_addr = s_addr[grant];
      m_wdat = s_wdat[grant];
    end
  end

  // The live grant takes precedence over the ownership table.
  always_comb begin
    tgt_vld = 1'b0;
    tgt     = '0;
    cb_clr  = 1'b0;
    if (resp_ok) begin
      if (hit_grant) begin
        tgt_vld = 1'b1;
        tgt     = grant;
      end else if (own_vld[m_resp]) begin
        tgt_vld = 1'b1;
        tgt     = own_port[m_resp];
        cb_clr  = (m_miss == 8'd0);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < nport; i++) begin
      s_resp[i] = (tgt_vld && tgt == pw'(i)) ? m_resp : 8'd0;
      s_miss[i] = (tgt_vld && tgt == pw'(i)) ? m_miss : 8'd0;
      s_ofst[i] = m_ofst;
      s_rdat[i] = m_rdat;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      grant   <= '0;
      gid     <= '0;
      rr_ptr  <= '0;
      own_vld <= '0;
    end else begin
      case (state)
        IDLE: if (|cand) begin
          state  <= BUSY;
          grant  <= win;
          gid    <= s_rqst[win];
          rr_ptr <= rr_nxt;
        end
        default: if (hit_grant || !keep) state <= IDLE;
      endcase
      // Later assignments win per bit: a fresh insert beats a final callback clear.
      own_vld <= own_vld & ~flush_m;
      if (cb_clr)  own_vld[m_resp] <= 1'b0;
      if (own_ins) own_vld[m_miss] <= 1'b1;
    end
  end

  // NOTE: the port table is not reset; own_vld alone qualifies every entry.
  always_ff @(posedge clk) begin
    if (own_ins) own_port[m_miss] <= grant;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: expectations are queued as stimulus is driven and compared mid-cycle.
module tb_mem_arbiter;

  localparam int nport = 2;
  localparam int blk   = 64;

`ifdef MEM_ARB_FIXED_PRIO_EN
  localparam bit rr = 1'b0;
`else
  localparam bit rr = 1'b1;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [255:0]     flush;
  logic [7:0]       s_rqst [nport];
  logic [7:0]       s_trsc [nport];
  logic [blk-1:0]   s_strb [nport];
  logic [63:0]      s_addr [nport];
  logic [blk*8-1:0] s_wdat [nport];
  logic [7:0]       s_resp [nport];
  logic [7:0]       s_miss [nport];
  logic [63:0]      s_ofst [nport];
  logic [blk*8-1:0] s_rdat [nport];
  logic [7:0]       m_rqst, m_trsc;
  logic [blk-1:0]   m_strb;
  logic [63:0]      m_addr;
  logic [blk*8-1:0] m_wdat;
  logic [7:0]       m_resp, m_miss;
  logic [63:0]      m_ofst;
  logic [blk*8-1:0] m_rdat;

  mem_arbiter #(.nport(nport), .blk(blk)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .s_rqst(s_rqst), .s_trsc(s_trsc), .s_strb(s_strb), .s_addr(s_addr), .s_wdat(s_wdat),
    .s_resp(s_resp), .s_miss(s_miss), .s_ofst(s_ofst), .s_rdat(s_rdat),
    .m_rqst(m_rqst), .m_trsc(m_trsc), .m_strb(m_strb), .m_addr(m_addr), .m_wdat(m_wdat),
    .m_resp(m_resp), .m_miss(m_miss), .m_ofst(m_ofst), .m_rdat(m_rdat)
  );

  always #5 clk = ~clk;

  typedef enum {M_RQST, M_ADDR, M_STRB, S_RESP0, S_RESP1, S_MISS0, S_MISS1, S_OFST1, S_RDAT1} sel_e;
  typedef struct {
    sel_e        sel;
    logic [63:0] v;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic logic [63:0] probe(input sel_e sel);
    case (sel)
      M_RQST:  return 64'(m_rqst);
      M_ADDR:  return m_addr;
      M_STRB:  return 64'(m_strb);
      S_RESP0: return 64'(s_resp[0]);
      S_RESP1: return 64'(s_resp[1]);
      S_MISS0: return 64'(s_miss[0]);
      S_MISS1: return 64'(s_miss[1]);
      S_OFST1: return s_ofst[1];
      default: return s_rdat[1][63:0];
    endcase
  endfunction

  task automatic expect_val(input sel_e sel, input logic [63:0] v, input string tag);
    exp_t e;
    e.sel = sel;
    e.v   = v;
    e.tag = tag;
    sb.push_back(e);
  endtask

  // Compare everything queued for this cycle at the falling edge, then move to the next drive point.
  task automatic cycle();
    exp_t        e;
    logic [63:0] obs;
    @(negedge clk);
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = probe(e.sel);
      n_chk++;
      assert (obs === e.v) n_pass++;
      else $error("FAIL %s: observed %h expected %h", e.tag, obs, e.v);
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk)
    if (!rst) assert (!(s_rqst[0] != 8'd0 && s_rqst[0] == s_rqst[1]))
      else $error("duplicate live request ID %h", s_rqst[0]);

  initial begin
    rst    = 1'b1;
    flush  = '0;
    m_resp = '0;
    m_miss = '0;
    m_ofst = 64'h1234;
    m_rdat = '0;
    m_rdat[63:0] = 64'hCAFE;
    for (int i = 0; i < nport; i++) begin
      s_rqst[i] = '0;
      s_trsc[i] = 8'(i + 1);
      s_wdat[i] = '0;
    end
    s_addr[0] = 64'h1000;
    s_addr[1] = 64'h2000_1000;
    s_strb[0] = 64'hF;
    s_strb[1] = 64'hF0;

    // Reset state
    cycle();
    expect_val(M_RQST, 0, "rst_m_rqst");
    expect_val(M_ADDR, 0, "rst_m_addr");
    expect_val(S_RESP0, 0, "rst_s_resp0");
    expect_val(S_RESP1, 0, "rst_s_resp1");
    expect_val(S_OFST1, 64'h1234, "rst_s_ofst");
    expect_val(S_RDAT1, 64'hCAFE, "rst_s_rdat");
    cycle();
    rst = 1'b0;

    // Single request from port 0
    s_rqst[0] = 8'h08;
    expect_val(M_RQST, 0, "t1_arb_cycle");
    cycle();
    expect_val(M_RQST, 8'h08, "t1_grant_rqst");
    expect_val(M_ADDR, 64'h1000, "t1_grant_addr");
    expect_val(M_STRB, 64'hF, "t1_grant_strb");
    cycle();
    expect_val(M_RQST, 8'h08, "t1_hold");
    cycle();
    m_resp = 8'h08;
    expect_val(S_RESP0, 8'h08, "t1_resp0");
    expect_val(S_RESP1, 0, "t1_resp1");
    expect_val(S_MISS0, 0, "t1_miss0");
    cycle();
    m_resp = 8'h00;
    expect_val(M_RQST, 0, "t1_idle_after_accept");
    cycle();
    s_rqst[0] = 8'h00;
    expect_val(M_RQST, 0, "t1_withdraw");
    cycle();
    cycle();

    rst = 1'b1;
    cycle();
    rst = 1'b0;

    // Two held requesters
    s_rqst[0] = 8'h08;
    s_rqst[1] = 8'h48;
    expect_val(M_RQST, 0, "t2_arb0");
    cycle();
    m_resp = 8'h08;
    expect_val(M_RQST, 8'h08, "t2_grant0");
    expect_val(S_RESP0, 8'h08, "t2_resp0");
    expect_val(S_RESP1, 0, "t2_resp0_other");
    cycle();
    m_resp = 8'h00;
    expect_val(M_RQST, 0, "t2_arb1");
    cycle();
    m_resp = rr ? 8'h48 : 8'h08;
    expect_val(M_RQST, rr ? 64'h48 : 64'h08, "t2_grant1");
    expect_val(M_ADDR, rr ? 64'h2000_1000 : 64'h1000, "t2_grant1_addr");
    expect_val(S_RESP1, rr ? 64'h48 : 64'h00, "t2_resp1");
    expect_val(S_RESP0, rr ? 64'h00 : 64'h08, "t2_resp1_other");
    cycle();
    m_resp = 8'h00;
    expect_val(M_RQST, 0, "t2_arb2");
    cycle();
    m_resp = 8'h08;
    expect_val(M_RQST, 8'h08, "t2_grant2");
    cycle();

    // Port 1 miss and later callbacks
    s_rqst[0] = 8'h00;
    m_resp    = 8'h00;
    expect_val(M_RQST, 0, "t3_arb");
    cycle();
    m_resp = 8'h48;
    m_miss = 8'h90;
    expect_val(M_RQST, 8'h48, "t3_grant");
    expect_val(S_RESP1, 8'h48, "t3_resp1");
    expect_val(S_MISS1, 8'h90, "t3_miss1");
    expect_val(S_RESP0, 0, "t3_resp0");
    cycle();
    s_rqst[1] = 8'h00;
    m_resp    = 8'h00;
    m_miss    = 8'h00;
    for (int i = 0; i < 9; i++) cycle();
    m_resp = 8'h90;
    m_miss = 8'h05;
    expect_val(S_RESP1, 8'h90, "t3_cb_partial_resp");
    expect_val(S_MISS1, 8'h05, "t3_cb_partial_miss");
    expect_val(S_RESP0, 0, "t3_cb_partial_other");
    cycle();
    m_miss = 8'h00;
    expect_val(S_RESP1, 8'h90, "t3_cb_final_resp");
    expect_val(S_MISS1, 0, "t3_cb_final_miss");
    cycle();
    expect_val(S_RESP1, 0, "t3_cb_after_clear");
    expect_val(S_RESP0, 0, "t3_cb_after_clear0");
    cycle();

    // Callback with no owner
    m_resp = 8'h33;
    expect_val(S_RESP0, 0, "t4_orphan0");
    expect_val(S_RESP1, 0, "t4_orphan1");
    cycle();
    m_resp = 8'h00;

    // Flush during a grant, then flush of an owned miss ID
    s_rqst[1] = 8'h48;
    expect_val(M_RQST, 0, "t5_arb");
    cycle();
    expect_val(M_RQST, 8'h48, "t5_grant");
    cycle();
    flush[8'h48] = 1'b1;
    expect_val(M_RQST, 0, "t5_flush_gate");
    cycle();
    flush = '0;
    expect_val(M_RQST, 0, "t5_idle_after_flush");
    cycle();
    m_resp = 8'h48;
    m_miss = 8'h90;
    expect_val(M_RQST, 8'h48, "t5_regrant");
    expect_val(S_RESP1, 8'h48, "t5_resp1");
    cycle();
    s_rqst[1]    = 8'h00;
    m_resp       = 8'h00;
    m_miss       = 8'h00;
    flush[8'h90] = 1'b1;
    cycle();
    flush  = '0;
    m_resp = 8'h90;
    expect_val(S_RESP1, 0, "t5_flushed_cb");
    cycle();

    // Reset with two owned IDs
    m_resp    = 8'h00;
    s_rqst[0] = 8'h08;
    expect_val(M_RQST, 0, "t6_arb0");
    cycle();
    m_resp = 8'h08;
    m_miss = 8'hA0;
    expect_val(M_RQST, 8'h08, "t6_grant0");
    expect_val(S_MISS0, 8'hA0, "t6_miss0");
    cycle();
    s_rqst[0] = 8'h00;
    s_rqst[1] = 8'h48;
    m_resp    = 8'h00;
    m_miss    = 8'h00;
    cycle();
    m_resp = 8'h48;
    m_miss = 8'h90;
    expect_val(S_RESP1, 8'h48, "t6_resp1");
    cycle();
    s_rqst[1] = 8'h00;
    s_rqst[0] = 8'h0C;
    m_resp    = 8'hA0;
    m_miss    = 8'h07;
    expect_val(S_RESP0, 8'hA0, "t6_owned_cb0");
    expect_val(S_RESP1, 0, "t6_owned_cb0_other");
    cycle();
    m_resp = 8'h00;
    m_miss = 8'h00;
    rst    = 1'b1;
    expect_val(M_RQST, 8'h0C, "t6_busy_before_rst");
    cycle();
    rst       = 1'b0;
    s_rqst[0] = 8'h00;
    expect_val(M_RQST, 0, "t6_post_rst_rqst");
    expect_val(M_ADDR, 0, "t6_post_rst_addr");
    expect_val(M_STRB, 0, "t6_post_rst_strb");
    expect_val(S_RESP0, 0, "t6_post_rst_resp0");
    cycle();
    m_resp = 8'hA0;
    expect_val(S_RESP0, 0, "t6_dropped_a0");
    expect_val(S_RESP1, 0, "t6_dropped_a0_other");
    cycle();
    m_resp = 8'h90;
    expect_val(S_RESP1, 0, "t6_dropped_90");
    expect_val(S_RESP0, 0, "t6_dropped_90_other");
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
